// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined compare unit: function codes, legacy
// result constants and the S1 stage record.
package cmp_pkg;

  // Operands are widened to this width inside the pipe; DATA_WIDTH must not exceed it.
  localparam int CMP_MAX_DW = 64;

  localparam logic [2:0] FUNC_NOP = 3'd0;
  localparam logic [2:0] FUNC_EQ  = 3'd1;
  localparam logic [2:0] FUNC_GT  = 3'd2;
  localparam logic [2:0] FUNC_LT  = 3'd3;
  localparam logic [2:0] FUNC_NE  = 3'd4;
  localparam logic [2:0] FUNC_GE  = 3'd5;
  localparam logic [2:0] FUNC_MAX = 3'd6;
  localparam logic [2:0] FUNC_MIN = 3'd7;

  localparam logic [1:0] RES_EQ = 2'd1;
  localparam logic [1:0] RES_GT = 2'd2;
  localparam logic [1:0] RES_LT = 2'd3;

  typedef struct packed {
    logic [CMP_MAX_DW-1:0] a;
    logic [CMP_MAX_DW-1:0] b;
    logic [2:0]            func;
    logic                  signed_mode;
    logic                  valid;
  } stage_t;

  // Predicate functions (EQ..GE) are the ones whose non-zero result is a "match".
  function automatic logic is_predicate(input logic [2:0] func);
    return (func >= FUNC_EQ) && (func <= FUNC_GE);
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational compare evaluator. Operands arrive already extended to
// CMP_MAX_DW according to signed_mode, so one wide compare serves both modes.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [CMP_MAX_DW-1:0] a,
  input  logic [CMP_MAX_DW-1:0] b,
  input  logic [2:0]            func,
  input  logic                  signed_mode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag
);

  logic eq;
  logic gt;
  logic lt;

  assign eq = (a == b);
  assign gt = signed_mode ? ($signed(a) > $signed(b)) : (a > b);
  assign lt = signed_mode ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    result = '0;
    case (func)
      FUNC_EQ:  result = eq ? DATA_WIDTH'(RES_EQ) : '0;
      FUNC_GT:  result = gt ? DATA_WIDTH'(RES_GT) : '0;
      FUNC_LT:  result = lt ? DATA_WIDTH'(RES_LT) : '0;
      FUNC_NE:  result = eq ? '0 : DATA_WIDTH'(1'b1);
      FUNC_GE:  result = lt ? '0 : DATA_WIDTH'(1'b1);
      // Ties fall through to A for both MAX and MIN.
      FUNC_MAX: result = DATA_WIDTH'(lt ? b : a);
      FUNC_MIN: result = DATA_WIDTH'(gt ? b : a);
      default:  result = '0;
    endcase
  end

  assign flag = (func != FUNC_NOP);

endmodule

// File: rtl/cmp_pipe_unit.sv
// Two-stage valid/ready compare unit (S1 operand register, S2 result register).
// Optional saturating match counter enabled by defining CMP_MATCH_CNT_EN.
module cmp_pipe_unit
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALU_FUNC,
  input  logic                  SIGNED_MODE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] CMP_OUT,
  output logic                  CMP_Flag
`ifdef CMP_MATCH_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  MATCH_CNT,
  input  logic                  CNT_CLR
`endif
);

  if (DATA_WIDTH < 2 || DATA_WIDTH > CMP_MAX_DW || CNT_WIDTH < 1) begin : g_param_check
    $error("cmp_pipe_unit: unsupported DATA_WIDTH/CNT_WIDTH");
  end

  stage_t                s1_reg;
  stage_t                s1_next;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] cmp_out_reg;
  logic                  cmp_flag_reg;
  logic [DATA_WIDTH-1:0] core_result;
  logic                  core_flag;
  logic                  adv;

  assign adv       = ~out_valid_reg | OUT_READY;
  assign IN_READY  = adv & ~FLUSH;
  assign OUT_VALID = out_valid_reg;
  assign CMP_OUT   = cmp_out_reg;
  assign CMP_Flag  = cmp_flag_reg;

  // Extend operands by mode at capture time so the core compares at one width.
  always_comb begin
    s1_next.a           = SIGNED_MODE ? CMP_MAX_DW'($signed(A)) : CMP_MAX_DW'(A);
    s1_next.b           = SIGNED_MODE ? CMP_MAX_DW'($signed(B)) : CMP_MAX_DW'(B);
    s1_next.func        = ALU_FUNC;
    s1_next.signed_mode = SIGNED_MODE;
    s1_next.valid       = IN_VALID;
  end

  cmp_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .a          (s1_reg.a),
    .b          (s1_reg.b),
    .func       (s1_reg.func),
    .signed_mode(s1_reg.signed_mode),
    .result     (core_result),
    .flag       (core_flag)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_reg        <= '0;
      out_valid_reg <= 1'b0;
      cmp_out_reg   <= '0;
      cmp_flag_reg  <= 1'b0;
    end else if (FLUSH) begin
      s1_reg.valid  <= 1'b0;
      out_valid_reg <= 1'b0;
      cmp_out_reg   <= '0;
      cmp_flag_reg  <= 1'b0;
    end else if (adv) begin
      s1_reg        <= s1_next;
      out_valid_reg <= s1_reg.valid;
      cmp_out_reg   <= s1_reg.valid ? core_result : '0;
      cmp_flag_reg  <= s1_reg.valid & core_flag;
    end
  end

`ifdef CMP_MATCH_CNT_EN
  logic                 s2_hit_reg;
  logic [CNT_WIDTH-1:0] match_cnt_reg;

  assign MATCH_CNT = match_cnt_reg;

  // s2_hit_reg tracks whether the result now held in S2 counts as a match.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_hit_reg    <= 1'b0;
      match_cnt_reg <= '0;
    end else begin
      if (FLUSH) begin
        s2_hit_reg <= 1'b0;
      end else if (adv) begin
        s2_hit_reg <= s1_reg.valid & is_predicate(s1_reg.func) & (core_result != '0);
      end

      if (CNT_CLR) begin
        match_cnt_reg <= '0;
      end else if (out_valid_reg && OUT_READY && s2_hit_reg && (match_cnt_reg != '1)) begin
        match_cnt_reg <= match_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Directed self-checking bench for cmp_pipe_unit (DATA_WIDTH=8, CNT_WIDTH=2).
module tb_cmp_pipe_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FLUSH;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] ALU_FUNC;
  logic       SIGNED_MODE;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] CMP_OUT;
  logic       CMP_Flag;
`ifdef CMP_MATCH_CNT_EN
  logic [1:0] MATCH_CNT;
  logic       CNT_CLR;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  cmp_pipe_unit #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FLUSH      (FLUSH),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .A          (A),
    .B          (B),
    .ALU_FUNC   (ALU_FUNC),
    .SIGNED_MODE(SIGNED_MODE),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .CMP_OUT    (CMP_OUT),
    .CMP_Flag   (CMP_Flag)
`ifdef CMP_MATCH_CNT_EN
    ,
    .MATCH_CNT  (MATCH_CNT),
    .CNT_CLR    (CNT_CLR)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("ok   %s: %0h", tag, obs);
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction: offer, check 2-cycle latency, result and flag.
  task automatic run1(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] f, input logic m,
                      input logic [7:0] exp_out, input logic exp_flag, input logic clr);
    @(posedge CLK); #1;
    A = a; B = b; ALU_FUNC = f; SIGNED_MODE = m; IN_VALID = 1'b1;
    #1 check({tag, " in_ready"}, 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check({tag, " early_valid"}, 32'(OUT_VALID), 32'd0);
    @(posedge CLK); #1;
`ifdef CMP_MATCH_CNT_EN
    CNT_CLR = clr;
`endif
    check({tag, " out_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, " cmp_out"}, 32'(CMP_OUT), 32'(exp_out));
    check({tag, " cmp_flag"}, 32'(CMP_Flag), 32'(exp_flag));
    @(posedge CLK); #1;
`ifdef CMP_MATCH_CNT_EN
    CNT_CLR = 1'b0;
`endif
    if (clr) ; // clear strobe only meaningful with the counter build
  endtask

  logic [7:0] bp_exp [6];
  int         sent;
  int         got;
  int         first_ov;

  initial begin
    RST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; A = '0; B = '0;
    ALU_FUNC = 3'd0; SIGNED_MODE = 1'b0; OUT_READY = 1'b1;
`ifdef CMP_MATCH_CNT_EN
    CNT_CLR = 1'b0;
`endif
    #2;
    check("reset out_valid", 32'(OUT_VALID), 32'd0);
    check("reset cmp_out", 32'(CMP_OUT), 32'd0);
    check("reset cmp_flag", 32'(CMP_Flag), 32'd0);
    check("reset in_ready", 32'(IN_READY), 32'd1);
`ifdef CMP_MATCH_CNT_EN
    check("reset match_cnt", 32'(MATCH_CNT), 32'd0);
`endif
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;

    // Signedness and ordering
    run1("gt_signed",   8'hFF, 8'h01, 3'd2, 1'b1, 8'h00, 1'b1, 1'b0);
    run1("gt_unsigned", 8'hFF, 8'h01, 3'd2, 1'b0, 8'h02, 1'b1, 1'b0);
    run1("max_signed",  8'h80, 8'h7F, 3'd6, 1'b1, 8'h7F, 1'b1, 1'b0);
    run1("min_signed",  8'h80, 8'h7F, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0);
    run1("max_unsigned", 8'h80, 8'h7F, 3'd6, 1'b0, 8'h80, 1'b1, 1'b0);
    run1("min_unsigned", 8'h80, 8'h7F, 3'd7, 1'b0, 8'h7F, 1'b1, 1'b0);
    run1("max_equal",   8'h33, 8'h33, 3'd6, 1'b0, 8'h33, 1'b1, 1'b0);
    run1("min_equal_s", 8'h33, 8'h33, 3'd7, 1'b1, 8'h33, 1'b1, 1'b0);

    // Legacy codes, NE and NOP
    run1("eq_5_5",  8'd5, 8'd5, 3'd1, 1'b0, 8'd1, 1'b1, 1'b0);
    run1("lt_5_5",  8'd5, 8'd5, 3'd3, 1'b0, 8'd0, 1'b1, 1'b0);
    run1("ge_5_5",  8'd5, 8'd5, 3'd5, 1'b0, 8'd1, 1'b1, 1'b0);
    run1("nop_5_5", 8'd5, 8'd5, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    run1("ne_5_6",  8'd5, 8'd6, 3'd4, 1'b0, 8'd1, 1'b1, 1'b0);
    run1("lt_s_neg", 8'hFE, 8'h02, 3'd3, 1'b1, 8'd3, 1'b1, 1'b0);
    run1("ge_u_small", 8'h02, 8'hFE, 3'd5, 1'b0, 8'd0, 1'b1, 1'b0);

    // Backpressure: 6 back-to-back MAX(a,0) results, 4-cycle stall after first OUT_VALID
    for (int i = 0; i < 6; i++) bp_exp[i] = 8'(16 * i + 5);
    sent = 0; got = 0; first_ov = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge CLK); #1;
      if (OUT_VALID && first_ov < 0) first_ov = cyc;
      OUT_READY = !(first_ov >= 0 && cyc < first_ov + 4);
      IN_VALID = (sent < 6);
      A = (sent < 6) ? bp_exp[sent] : 8'h00;
      B = 8'h00; ALU_FUNC = 3'd6; SIGNED_MODE = 1'b0;
      #1;
      if (!OUT_READY) begin
        check("bp stall in_ready", 32'(IN_READY), 32'd0);
        check("bp stall cmp_out", 32'(CMP_OUT), 32'(bp_exp[0]));
      end
      if (IN_VALID && IN_READY) sent++;
      if (OUT_VALID && OUT_READY) begin
        if (got < 6) check($sformatf("bp result %0d", got), 32'(CMP_OUT), 32'(bp_exp[got]));
        else check("bp duplicate", 32'(got), 32'd5);
        got++;
      end
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    check("bp first_valid cycle", 32'(first_ov), 32'd2);
    check("bp sent", 32'(sent), 32'd6);
    check("bp delivered", 32'(got), 32'd6);

    // FLUSH with two in flight, output stalled
    @(posedge CLK); #1;
    A = 8'd9; B = 8'd9; ALU_FUNC = 3'd1; SIGNED_MODE = 1'b0; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    A = 8'd3; B = 8'd4;
    @(posedge CLK); #1;
    FLUSH = 1'b1; OUT_READY = 1'b0; A = 8'd7; B = 8'd7;
    #1;
    check("flush pre out_valid", 32'(OUT_VALID), 32'd1);
    check("flush in_ready", 32'(IN_READY), 32'd0);
    @(posedge CLK); #1;
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    check("flush out_valid", 32'(OUT_VALID), 32'd0);
    check("flush cmp_out", 32'(CMP_OUT), 32'd0);
    check("flush cmp_flag", 32'(CMP_Flag), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check($sformatf("flush stale %0d", i), 32'(OUT_VALID), 32'd0);
    end

    // Asynchronous reset mid-stream
    @(posedge CLK); #1;
    A = 8'd7; B = 8'd7; ALU_FUNC = 3'd1; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    A = 8'd1; B = 8'd2;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check("mid pre out_valid", 32'(OUT_VALID), 32'd1);
    check("mid pre cmp_out", 32'(CMP_OUT), 32'd1);
    RST = 1'b0;
    #1;
    check("mid rst out_valid", 32'(OUT_VALID), 32'd0);
    check("mid rst cmp_out", 32'(CMP_OUT), 32'd0);
    check("mid rst cmp_flag", 32'(CMP_Flag), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    check("mid post out_valid", 32'(OUT_VALID), 32'd0);
    run1("post_rst_min", 8'h10, 8'h20, 3'd7, 1'b0, 8'h10, 1'b1, 1'b0);

`ifdef CMP_MATCH_CNT_EN
    // Saturating match counter, 2 bits wide
    check("cnt start", 32'(MATCH_CNT), 32'd0);
    run1("cnt_eq1", 8'd4, 8'd4, 3'd1, 1'b0, 8'd1, 1'b1, 1'b0);
    check("cnt after 1", 32'(MATCH_CNT), 32'd1);
    run1("cnt_eq2", 8'd4, 8'd4, 3'd1, 1'b0, 8'd1, 1'b1, 1'b0);
    check("cnt after 2", 32'(MATCH_CNT), 32'd2);
    run1("cnt_eq3", 8'd4, 8'd4, 3'd1, 1'b0, 8'd1, 1'b1, 1'b0);
    check("cnt after 3", 32'(MATCH_CNT), 32'd3);
    run1("cnt_eq4", 8'd4, 8'd4, 3'd1, 1'b0, 8'd1, 1'b1, 1'b0);
    check("cnt after 4", 32'(MATCH_CNT), 32'd3);
    run1("cnt_eq5", 8'd4, 8'd4, 3'd1, 1'b0, 8'd1, 1'b1, 1'b0);
    check("cnt after 5", 32'(MATCH_CNT), 32'd3);
    run1("cnt_max", 8'h33, 8'h33, 3'd6, 1'b0, 8'h33, 1'b1, 1'b0);
    check("cnt after max", 32'(MATCH_CNT), 32'd3);
    run1("cnt_clr", 8'd4, 8'd4, 3'd1, 1'b0, 8'd1, 1'b1, 1'b1);
    check("cnt after clr", 32'(MATCH_CNT), 32'd0);
    run1("cnt_eq6", 8'd4, 8'd4, 3'd1, 1'b0, 8'd1, 1'b1, 1'b0);
    check("cnt after clr+1", 32'(MATCH_CNT), 32'd1);
    run1("cnt_eq_miss", 8'd4, 8'd5, 3'd1, 1'b0, 8'd0, 1'b1, 1'b0);
    check("cnt after miss", 32'(MATCH_CNT), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
